// File: rtl/cuadro_button_encoder.sv
// Button front-end for the tic-tac-toe FSM: synchronise, debounce, validate and time
// one square selection per physical press.
module cuadro_button_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100,
    parameter int GAP_CYCLES      = 100
) (
    input  logic       clk_100MHz,
    input  logic       restart,
    input  logic [8:0] btn_raw,
    input  logic [8:0] x,
    input  logic [8:0] o,
    output logic [8:0] cuadro,
    output logic       busy,
    output logic       rejected
);

    localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW    = $clog2(TMAX + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP, WAIT_REL} state_t;

    logic [8:0]    sync1_q, sync_q, stable_q, stable_dly_q;
    logic [DW-1:0] db_cnt_q;
    logic [8:0]    press;
    logic          multi, occupied;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    cuadro_q, cuadro_d;
    logic          rej_q, rej_d;

    // One shared counter: the whole vector must sit still for DEBOUNCE_CYCLES.
    always_ff @(posedge clk_100MHz) begin
        if (restart) begin
            sync1_q      <= '0;
            sync_q       <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync_q       <= sync1_q;
            stable_dly_q <= stable_q;
            if (sync_q != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_q <= sync_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign press    = stable_q & ~stable_dly_q;
    assign multi    = |(press & (press - 9'd1));
    assign occupied = |(press & (x | o));

    always_ff @(posedge clk_100MHz) begin
        if (restart) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cuadro_q <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cuadro_q <= cuadro_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cuadro_d = cuadro_q;
        rej_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press != '0) begin
                    if (multi || occupied) begin
                        rej_d   = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        cuadro_d = press;
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cuadro_d = '0;
                    cnt_d    = '0;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                cuadro_d = '0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_REL: begin
                // Re-arm only once every button is released, so a held button selects once.
                if (stable_q == '0) state_d = IDLE;
            end
            default: begin
                cuadro_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    assign cuadro   = cuadro_q;
    assign rejected = rej_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cuadro_button_encoder.sv
// Directed bench for cuadro_button_encoder with short debounce/hold/gap timing.
module tb_cuadro_button_encoder;

    logic       clk_100MHz = 1'b0;
    logic       restart;
    logic [8:0] btn_raw, x, o;
    logic [8:0] cuadro;
    logic       busy, rejected;

    int checks   = 0;
    int failures = 0;

    cuadro_button_encoder #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (3),
        .GAP_CYCLES     (2)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .restart   (restart),
        .btn_raw   (btn_raw),
        .x         (x),
        .o         (o),
        .cuadro    (cuadro),
        .busy      (busy),
        .rejected  (rejected)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int nz;

    initial begin
        restart = 1'b1; btn_raw = '0; x = '0; o = '0;
        tick(2);
        chk("rst_cuadro", cuadro, 9'h000);
        chk("rst_busy", {8'd0, busy}, 9'd0);
        chk("rst_rejected", {8'd0, rejected}, 9'd0);
        restart = 1'b0;
        tick(2);

        // 1: clean press of square 3, held
        btn_raw = 9'h008;
        tick(6);
        chk("t1_cuadro_c6", cuadro, 9'h000);
        chk("t1_busy_c6", {8'd0, busy}, 9'd0);
        tick(1);
        chk("t1_cuadro_c7", cuadro, 9'h008);
        chk("t1_busy_c7", {8'd0, busy}, 9'd1);
        tick(1); chk("t1_cuadro_c8", cuadro, 9'h008);
        tick(1); chk("t1_cuadro_c9", cuadro, 9'h008);
        tick(1); chk("t1_cuadro_c10", cuadro, 9'h000);
        chk("t1_busy_c10", {8'd0, busy}, 9'd1);
        tick(2);
        chk("t1_busy_c12", {8'd0, busy}, 9'd1);
        btn_raw = 9'h000;
        tick(6);
        chk("t1_busy_rel6", {8'd0, busy}, 9'd1);
        tick(1);
        chk("t1_busy_rel7", {8'd0, busy}, 9'd0);
        chk("t1_cuadro_end", cuadro, 9'h000);
        tick(2);

        // 2: bouncing bit 0 never debounces
        for (int i = 0; i < 5; i++) begin
            btn_raw = 9'h001;
            tick(1); chk("t2_cuadro", cuadro, 9'h000); chk("t2_rej", {8'd0, rejected}, 9'd0);
            tick(1); chk("t2_cuadro", cuadro, 9'h000); chk("t2_rej", {8'd0, rejected}, 9'd0);
            btn_raw = 9'h000;
            tick(1); chk("t2_cuadro", cuadro, 9'h000); chk("t2_rej", {8'd0, rejected}, 9'd0);
            tick(1); chk("t2_cuadro", cuadro, 9'h000); chk("t2_rej", {8'd0, rejected}, 9'd0);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t2_settle_cuadro", cuadro, 9'h000);
            chk("t2_settle_rej", {8'd0, rejected}, 9'd0);
            chk("t2_settle_busy", {8'd0, busy}, 9'd0);
        end

        // 3: occupied square rejected
        x = 9'h001;
        btn_raw = 9'h001;
        tick(6);
        chk("t3_rej_c6", {8'd0, rejected}, 9'd0);
        tick(1);
        chk("t3_rej_c7", {8'd0, rejected}, 9'd1);
        chk("t3_cuadro_c7", cuadro, 9'h000);
        chk("t3_busy_c7", {8'd0, busy}, 9'd1);
        tick(1);
        chk("t3_rej_c8", {8'd0, rejected}, 9'd0);
        chk("t3_cuadro_c8", cuadro, 9'h000);
        btn_raw = 9'h000;
        tick(7);
        chk("t3_idle", {8'd0, busy}, 9'd0);
        x = 9'h000;
        tick(2);

        // 4: two buttons at once rejected, then single press accepted
        btn_raw = 9'h090;
        tick(7);
        chk("t4_rej_c7", {8'd0, rejected}, 9'd1);
        chk("t4_cuadro_c7", cuadro, 9'h000);
        tick(1);
        chk("t4_rej_c8", {8'd0, rejected}, 9'd0);
        btn_raw = 9'h000;
        tick(7);
        chk("t4_idle", {8'd0, busy}, 9'd0);
        btn_raw = 9'h010;
        tick(7);
        chk("t4_cuadro_acc", cuadro, 9'h010);
        chk("t4_rej_acc", {8'd0, rejected}, 9'd0);
        btn_raw = 9'h000;
        tick(10);
        chk("t4_idle2", {8'd0, busy}, 9'd0);

        // 5: restart during hold, then a fresh press
        btn_raw = 9'h020;
        tick(7);
        chk("t5_cuadro_hold", cuadro, 9'h020);
        tick(1);
        restart = 1'b1;
        btn_raw = 9'h000;
        tick(1);
        chk("t5_rst_cuadro", cuadro, 9'h000);
        chk("t5_rst_busy", {8'd0, busy}, 9'd0);
        restart = 1'b0;
        btn_raw = 9'h040;
        tick(6);
        chk("t5_fresh_c6", cuadro, 9'h000);
        tick(1);
        chk("t5_fresh_c7", cuadro, 9'h040);
        btn_raw = 9'h000;
        tick(20);
        chk("t5_idle", {8'd0, busy}, 9'd0);

        // 6: button held through hold and gap selects only once
        btn_raw = 9'h004;
        nz = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (cuadro != 9'h000) nz++;
            if (i == 7) chk("t6_cuadro_c7", cuadro, 9'h004);
        end
        chk("t6_pulse_cycles", 9'(nz), 9'd3);
        chk("t6_busy_held", {8'd0, busy}, 9'd1);
        btn_raw = 9'h000;
        tick(8);
        chk("t6_idle", {8'd0, busy}, 9'd0);
        btn_raw = 9'h004;
        tick(6);
        chk("t6_again_c6", cuadro, 9'h000);
        tick(1);
        chk("t6_again_c7", cuadro, 9'h004);
        btn_raw = 9'h000;
        tick(20);
        chk("t6_final_busy", {8'd0, busy}, 9'd0);
        chk("t6_final_cuadro", cuadro, 9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
